// File: rtl/risc_v_mike_pkg.sv
// rtl/risc_v_mike_pkg.sv - shared types and widths for the mike core front end
package risc_v_mike_pkg;

  localparam int INSTR_32_W = 32;
  localparam int FETCH_PC_W = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } t_fetch_state;

  typedef struct packed {
    logic [INSTR_32_W-1:0] instr;
    logic [FETCH_PC_W-1:0] pc;
  } t_fetch_entry;

endpackage

// File: rtl/risc_v_mike_fetch_if.sv
// rtl/risc_v_mike_fetch_if.sv - instruction memory req/gnt/rvalid bus
interface risc_v_mike_fetch_if;
  import risc_v_mike_pkg::*;

  logic                  imem_req;
  logic [FETCH_PC_W-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [INSTR_32_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/risc_v_mike_fetch_fifo.sv
// rtl/risc_v_mike_fetch_fifo.sv - small sync FIFO of fetch entries with flush
module risc_v_mike_fetch_fifo
  import risc_v_mike_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  t_fetch_entry wdata,
  input  logic         pop,
  output t_fetch_entry rdata,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  t_fetch_entry   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/risc_v_mike_fetch.sv
// rtl/risc_v_mike_fetch.sv - fetch stage: PC owner, imem requester, instruction buffer
module risc_v_mike_fetch
  import risc_v_mike_pkg::*;
#(
  parameter logic [FETCH_PC_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  risc_v_mike_fetch_if.master   imem,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [INSTR_32_W-1:0] instruction,
  output logic [FETCH_PC_W-1:0] instr_pc,
  output logic [FETCH_PC_W-1:0] instr_pc_plus4,
  input  logic                  pc_src,
  input  logic [FETCH_PC_W-1:0] pc_target,
  output logic                  fetch_misaligned
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = 8;

  t_fetch_state          state, state_nxt;
  logic [FETCH_PC_W-1:0] fetch_pc;
  logic [OW-1:0]         outstanding, drop_cnt, out_nxt, live;
  logic                  redirect, gnt_fire, rsp_ok, rsp_keep, consume, can_issue;

  t_fetch_entry  ibuf_head, pcq_head;
  logic [CW-1:0] ibuf_count, pcq_count;
  logic          ibuf_empty, ibuf_full, pcq_empty, pcq_full;
  logic          unused_ok;

  assign redirect  = pc_src && (state == RUN);
  assign gnt_fire  = imem.imem_req && imem.imem_gnt;
  assign rsp_ok    = imem.imem_rvalid && (outstanding != '0);
  assign rsp_keep  = rsp_ok && (drop_cnt == '0) && !redirect && (state == RUN);
  assign consume   = instr_valid && instr_ready && !redirect;
  assign out_nxt   = outstanding + OW'(gnt_fire) - OW'(rsp_ok);
  // live = in-flight responses that will actually land in the buffer
  assign live      = outstanding - drop_cnt;
  assign can_issue = (OW'(ibuf_count) + live) < OW'(FIFO_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (redirect && (pc_target[1:0] != 2'b00)) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    imem.imem_req = (state == RUN) && !pc_src && can_issue;
  end

  assign imem.imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc         <= RESET_PC;
      outstanding      <= '0;
      drop_cnt         <= '0;
      fetch_misaligned <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      if (redirect) begin
        drop_cnt <= out_nxt;
        fetch_pc <= {pc_target[FETCH_PC_W-1:2], 2'b00};
        if (pc_target[1:0] != 2'b00) fetch_misaligned <= 1'b1;
      end else begin
        if (rsp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        if (gnt_fire) fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  // PC of every live request, in grant order, so responses can be tagged
  risc_v_mike_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (gnt_fire),
    .wdata ('{instr: '0, pc: fetch_pc}),
    .pop   (rsp_keep),
    .rdata (pcq_head),
    .count (pcq_count),
    .empty (pcq_empty),
    .full  (pcq_full)
  );

  risc_v_mike_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_instr_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (rsp_keep),
    .wdata ('{instr: imem.imem_rdata, pc: pcq_head.pc}),
    .pop   (consume),
    .rdata (ibuf_head),
    .count (ibuf_count),
    .empty (ibuf_empty),
    .full  (ibuf_full)
  );

  assign unused_ok      = ^{pcq_head.instr, pcq_count, pcq_empty, pcq_full, ibuf_full};
  assign instr_valid    = !ibuf_empty;
  assign instruction    = ibuf_head.instr;
  assign instr_pc       = ibuf_head.pc;
  assign instr_pc_plus4 = ibuf_head.pc + 32'd4;

  a_rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) imem.imem_rvalid |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_risc_v_mike_fetch.sv
// tb/tb_risc_v_mike_fetch.sv - scoreboard bench for the fetch stage
module tb_risc_v_mike_fetch;
  import risc_v_mike_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid, instr_ready, pc_src, fetch_misaligned;
  logic [31:0] instruction, instr_pc, instr_pc_plus4, pc_target;

  always #5 clk = ~clk;

  risc_v_mike_fetch_if imem_if ();

  risc_v_mike_fetch #(.RESET_PC(32'h100), .FIFO_DEPTH(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem             (imem_if),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instruction      (instruction),
    .instr_pc         (instr_pc),
    .instr_pc_plus4   (instr_pc_plus4),
    .pc_src           (pc_src),
    .pc_target        (pc_target),
    .fetch_misaligned (fetch_misaligned)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } mem_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mem_t        mq[$];
  exp_t        exp_q[$];
  logic [31:0] glog[$];
  int          n_cmp = 0, n_err = 0, cyc = 0, lat = 1, n_consumed = 0;
  bit          ready_v = 0, src_v = 0, gnt_v = 0, first_seen = 0, wrap_seen = 0;
  logic [31:0] tgt_v = '0, first_pc = '0, wrap_p4 = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  // One clock: drive inputs and memory at negedge, then settle and score.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    instr_ready      = ready_v;
    pc_src           = src_v;
    pc_target        = tgt_v;
    imem_if.imem_gnt = gnt_v;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_if.imem_rvalid = 1'b1;
      imem_if.imem_rdata  = mq[0].data;
      void'(mq.pop_front());
    end else begin
      imem_if.imem_rvalid = 1'b0;
      imem_if.imem_rdata  = '0;
    end
    #1;
    if (instr_valid && instr_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got pc %h instr %h, required no entry", instr_pc, instruction);
      end else begin
        e = exp_q.pop_front();
        if (instr_pc !== e.pc || instruction !== e.instr || instr_pc_plus4 !== e.pc + 32'd4) begin
          n_err++;
          $display("FAIL sb_entry: got pc %h instr %h plus4 %h, required pc %h instr %h plus4 %h",
                   instr_pc, instruction, instr_pc_plus4, e.pc, e.instr, e.pc + 32'd4);
        end
      end
      n_consumed++;
      if (!first_seen) begin first_seen = 1; first_pc = instr_pc; end
      if (instr_pc == 32'hFFFF_FFFC) begin wrap_seen = 1; wrap_p4 = instr_pc_plus4; end
    end
    if (pc_src) exp_q.delete();
    if (imem_if.imem_req) begin
      n_cmp++;
      if (imem_if.imem_addr[1:0] !== 2'b00 || pc_src) begin
        n_err++;
        $display("FAIL req_legal: got addr %h with pc_src %b, required aligned addr and pc_src 0",
                 imem_if.imem_addr, pc_src);
      end
    end
    if (imem_if.imem_req && imem_if.imem_gnt) begin
      glog.push_back(imem_if.imem_addr);
      mq.push_back('{addr: imem_if.imem_addr, data: mem_word(imem_if.imem_addr), due: cyc + lat});
      exp_q.push_back('{pc: imem_if.imem_addr, instr: mem_word(imem_if.imem_addr)});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_v = 0;
    imem_if.imem_rvalid = 1'b0;
    mq.delete(); exp_q.delete(); glog.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    first_seen = 0; n_consumed = 0; wrap_seen = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready_v = 0; gnt_v = 0;
    #12;
    n_cmp++;
    if (imem_if.imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_misaligned !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got req %b valid %b mis %b, required 0 0 0",
               imem_if.imem_req, instr_valid, fetch_misaligned);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++;
    if (imem_if.imem_req !== 1'b0) begin
      n_err++; $display("FAIL boot_no_req: got req %b, required 0", imem_if.imem_req);
    end
    step();
    n_cmp++;
    if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h100) begin
      n_err++; $display("FAIL first_req: got req %b addr %h, required 1 00000100", imem_if.imem_req, imem_if.imem_addr);
    end
    step();
    n_cmp++;
    if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h100) begin
      n_err++; $display("FAIL req_hold: got req %b addr %h, required 1 00000100", imem_if.imem_req, imem_if.imem_addr);
    end
  endtask

  task automatic test_basic();
    bit seen = 0;
    do_reset(); lat = 1; gnt_v = 1; ready_v = 1;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (imem_if.imem_rvalid) seen = 1;
    end
    n_cmp++;
    if (!seen || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL first_rvalid: got seen %b valid %b, required 1 0", seen, instr_valid);
    end
    step();
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_pc_plus4 !== 32'h104) begin
      n_err++; $display("FAIL rvalid_latency: got valid %b pc %h plus4 %h, required 1 00000100 00000104",
                        instr_valid, instr_pc, instr_pc_plus4);
    end
    repeat (10) step();
    n_cmp++;
    if (glog.size() < 3 || glog[0] !== 32'h100 || glog[1] !== 32'h104 || glog[2] !== 32'h108) begin
      n_err++; $display("FAIL addr_seq: got %0d grants, required 00000100 00000104 00000108 first", glog.size());
    end
    n_cmp++;
    if (n_consumed < 4) begin
      n_err++; $display("FAIL basic_flow: got %0d consumed, required at least 4", n_consumed);
    end
  endtask

  task automatic test_backpressure();
    do_reset(); lat = 1; gnt_v = 1; ready_v = 0;
    repeat (12) step();
    n_cmp++;
    if (glog.size() != 2 || imem_if.imem_req !== 1'b0) begin
      n_err++; $display("FAIL bp_throttle: got %0d grants req %b, required 2 grants req 0", glog.size(), imem_if.imem_req);
    end
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
      n_err++; $display("FAIL bp_hold: got valid %b pc %h, required 1 00000100", instr_valid, instr_pc);
    end
    ready_v = 1;
    repeat (12) step();
    n_cmp++;
    if (n_consumed < 4 || first_pc !== 32'h100) begin
      n_err++; $display("FAIL bp_drain: got %0d consumed first pc %h, required >=4 and 00000100", n_consumed, first_pc);
    end
  endtask

  task automatic test_redirect();
    do_reset(); lat = 3; gnt_v = 1; ready_v = 1;
    for (int i = 0; i < 10 && glog.size() < 2; i++) step();
    first_seen = 0;
    src_v = 1; tgt_v = 32'h200;
    step();
    n_cmp++;
    if (glog.size() != 2 || imem_if.imem_req !== 1'b0) begin
      n_err++; $display("FAIL redir_req: got %0d grants req %b, required 2 grants req 0", glog.size(), imem_if.imem_req);
    end
    src_v = 0;
    step();
    n_cmp++;
    if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h200) begin
      n_err++; $display("FAIL redir_addr: got req %b addr %h, required 1 00000200", imem_if.imem_req, imem_if.imem_addr);
    end
    repeat (15) step();
    n_cmp++;
    if (!first_seen || first_pc !== 32'h200) begin
      n_err++; $display("FAIL redir_first: got seen %b pc %h, required 1 00000200", first_seen, first_pc);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(); lat = 2; gnt_v = 1; ready_v = 1;
    repeat (5) step();
    first_seen = 0;
    src_v = 1; tgt_v = 32'h300; step();
    tgt_v = 32'h400; step();
    src_v = 0; step();
    n_cmp++;
    if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h400) begin
      n_err++; $display("FAIL b2b_addr: got req %b addr %h, required 1 00000400", imem_if.imem_req, imem_if.imem_addr);
    end
    repeat (12) step();
    n_cmp++;
    if (!first_seen || first_pc !== 32'h400) begin
      n_err++; $display("FAIL b2b_first: got seen %b pc %h, required 1 00000400", first_seen, first_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset(); lat = 1; gnt_v = 1; ready_v = 1;
    repeat (3) step();
    src_v = 1; tgt_v = 32'hFFFF_FFFC; step();
    src_v = 0; glog.delete();
    repeat (10) step();
    n_cmp++;
    if (glog.size() < 2 || glog[0] !== 32'hFFFF_FFFC || glog[1] !== 32'h0) begin
      n_err++; $display("FAIL wrap_addr: got %0d grants, required FFFFFFFC then 00000000", glog.size());
    end
    n_cmp++;
    if (!wrap_seen || wrap_p4 !== 32'h0) begin
      n_err++; $display("FAIL wrap_plus4: got seen %b plus4 %h, required 1 00000000", wrap_seen, wrap_p4);
    end
  endtask

  task automatic test_misaligned();
    bit bad = 0;
    do_reset(); lat = 2; gnt_v = 1; ready_v = 1;
    repeat (4) step();
    src_v = 1; tgt_v = 32'h202; step();
    src_v = 0; step();
    n_cmp++;
    if (fetch_misaligned !== 1'b1 || imem_if.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL mis_enter: got mis %b req %b valid %b, required 1 0 0",
                        fetch_misaligned, imem_if.imem_req, instr_valid);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      if (fetch_misaligned !== 1'b1 || imem_if.imem_req !== 1'b0 || instr_valid !== 1'b0) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_err++; $display("FAIL mis_sticky: got a cycle leaving halt, required mis 1 req 0 valid 0");
    end
    do_reset(); #1;
    n_cmp++;
    if (fetch_misaligned !== 1'b0) begin
      n_err++; $display("FAIL mis_clear: got mis %b after reset, required 0", fetch_misaligned);
    end
  endtask

  task automatic test_reset_midburst();
    bit bad = 0;
    do_reset(); lat = 3; gnt_v = 1; ready_v = 1;
    for (int i = 0; i < 10 && glog.size() < 2; i++) step();
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    n_cmp++;
    if (imem_if.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got req %b valid %b, required 0 0", imem_if.imem_req, instr_valid);
    end
    gnt_v = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (instr_valid !== 1'b0) bad = 1;
    end
    exp_q.delete(); glog.delete(); mq.delete();
    @(negedge clk); rst_n = 1'b1;
    step(); step();
    n_cmp++;
    if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h100) begin
      n_err++; $display("FAIL post_reset_addr: got req %b addr %h, required 1 00000100", imem_if.imem_req, imem_if.imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (instr_valid !== 1'b0) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_err++; $display("FAIL late_rvalid: got instr_valid during or after reset, required 0");
    end
  endtask

  initial begin
    instr_ready = 0; pc_src = 0; pc_target = '0;
    imem_if.imem_gnt = 0; imem_if.imem_rvalid = 0; imem_if.imem_rdata = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_misaligned();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required a finished run");
    $fatal(1);
  end

endmodule
